fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Holds each returned instruction, with its PC, for the decoder until the downstream stage accepts it.
- Redirects to branch/jump targets returned from execute, draining any in-flight memory request first.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
NOP_INSTR, 32'h0000_0013, value driven on instr when no instruction is held (addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  memory request; held high until imem_ack
imem_addr  output  32  request byte address; stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid only when imem_ack=1
instr  output  32  held instruction to decoder
pc  output  32  address of instr
pc_plus4  output  32  pc+4, combinational, mod 2^32
instr_valid  output  1  instr/pc are valid
instr_ready  input  1  downstream consumes instr this cycle
redirect  input  1  branch taken or jump
redirect_target  input  32  new fetch PC
misaligned  output  1  sticky: redirect_target[1:0]!=0 was received

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n. All state is registered and cleared asynchronously.
- Reset values: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, pc=RESET_PC, instr_valid=0, misaligned=0.
- States: IDLE, FETCH, HOLD, DRAIN, TRAP. imem_req=1 only in FETCH and DRAIN.
- IDLE: entered only via reset. Next cycle goes to FETCH, with imem_addr=fetch_pc.
- FETCH:
  - imem_req=1; imem_addr is held.
  - On imem_ack without redirect: instr<=imem_rdata, pc<=imem_addr, instr_valid<=1, fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC->0), go to HOLD.
  - Latency: ack to instr_valid=1 is one cycle.
- HOLD:
  - instr_valid=1; instr/pc are stable.
  - On instr_ready without redirect: instr_valid<=0, imem_addr<=fetch_pc, go to FETCH.
  - Minimum issue interval is 2 cycles per instruction when ack and ready arrive immediately.
- Redirect has priority over ack and ready in every state except IDLE/TRAP:
  - target[1:0]!=0: misaligned<=1, instr_valid<=0, instr<=NOP_INSTR, go to TRAP.
  - FETCH with imem_ack the same cycle: returned data is discarded; fetch_pc<=target, imem_addr<=target, stay in FETCH (new request next cycle).
  - FETCH without imem_ack: fetch_pc<=target, go to DRAIN. imem_req and the old imem_addr are held until the ack.
  - HOLD (including simultaneous instr_ready): instr_valid<=0, instr<=NOP_INSTR, fetch_pc<=target, imem_addr<=target, go to FETCH.
- DRAIN:
  - imem_req=1 at the stale address.
  - On imem_ack: data is discarded, imem_addr<=fetch_pc, go to FETCH.
  - A further redirect in DRAIN overwrites fetch_pc (last one wins) and stays in DRAIN.
- TRAP: imem_req=0, instr_valid=0, misaligned=1. Only reset exits.
- instr_valid never drops without instr_ready or redirect. imem_addr never changes while imem_req=1 and no ack.
- imem_ack while imem_req=0 is ignored.
- Reset asserted mid-request or mid-hold: all outputs return to reset values immediately (asynchronous). The pending ack is dropped.
- Widths: all PC arithmetic is unsigned 32-bit with silent wrap. No exceptions other than misalignment.

Test Plan:
- Reset release, memory acks every request in the same cycle, instr_ready=1 -> imem_addr sequence 0,4,8,...; instr_valid every other cycle; pc_plus4=pc+4.
- Backpressure: instr_ready=0 for 5 cycles in HOLD at pc=0x8 -> instr/pc stable, imem_req=0, no new address until ready; then fetch of 0xC.
- Redirect to 0x100 while a request to 0x10 waits 3 cycles for ack -> DRAIN holds addr 0x10 until ack, data is discarded, next request 0x100, and the first valid pc=0x100.
- Redirect to 0x40 in the same cycle as imem_ack at 0x20 -> no instr_valid for 0x20; next request 0x40.
- Redirect to 0x102 -> misaligned=1, imem_req=0, instr_valid=0 permanently until rst_n low, then fetch restarts at RESET_PC.
- Wrap: redirect to 0xFFFF_FFFC -> next sequential fetch address 0x0000_0000; rst_n pulsed low mid-FETCH -> outputs return to reset values without waiting for clk.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// over req/ack, and holds each returned instruction for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        misaligned
);

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        target_bad;

  assign target_bad = (redirect_target[1:0] != 2'b00);

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // path through the case statement can leave a signal unassigned (no latch).
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    mis_d      = mis_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        addr_d  = fetch_pc_q;
      end

      FETCH: begin
        if (redirect) begin
          if (target_bad) begin
            mis_d   = 1'b1;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = TRAP;
          end else if (imem_ack) begin
            // Returned word belongs to the old path; reissue at the target now.
            fetch_pc_d = redirect_target;
            addr_d     = redirect_target;
          end else begin
            // Request is still outstanding and must complete at its old address.
            fetch_pc_d = redirect_target;
            state_d    = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          pc_d       = addr_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (target_bad) begin
            mis_d   = 1'b1;
            state_d = TRAP;
          end else begin
            fetch_pc_d = redirect_target;
            addr_d     = redirect_target;
            state_d    = FETCH;
          end
        end else if (instr_ready) begin
          valid_d = 1'b0;
          addr_d  = fetch_pc_q;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          if (target_bad) begin
            mis_d   = 1'b1;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = TRAP;
          end else if (imem_ack) begin
            fetch_pc_d = redirect_target;
            addr_d     = redirect_target;
            state_d    = FETCH;
          end else begin
            fetch_pc_d = redirect_target;
          end
        end else if (imem_ack) begin
          addr_d  = fetch_pc_q;
          state_d = FETCH;
        end
      end

      TRAP: begin
        state_d = TRAP;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;

endmodule
